full_st1_tap_ctrl: RTL and testbench

FULL_ST1_TAP_CTRL -- requirements
Module: full_st1_tap_ctrl

---
 rtl/full_st1_tap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_full_st1_tap_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_st1_tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | full_st1_tap_ctrl: tap memory sequencer (forward sweep, row update, load)  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module full_st1_tap_ctrl #(
  parameter int AW    = 4,
  parameter int LANES = 6,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fwd_req,
  input  logic                fwd_inter,
  input  logic [AW-1:0]       fwd_rows,
  input  logic                fwd_hold,
  output logic                fwd_ack,
  output logic                fwd_done,
  output logic                rd_data_vld,
  input  logic                upd_vld,
  output logic                upd_rdy,
  input  logic [AW-1:0]       upd_addr,
  input  logic [LANES*DW-1:0] upd_data,
  input  logic                ld_vld,
  output logic                ld_rdy,
  input  logic [2:0]          ld_lane,
  input  logic [AW-1:0]       ld_addr,
  input  logic [DW-1:0]       ld_data,
  output logic                ld_err,
  output logic                busy,
  output logic [AW-1:0]       tap_rd_address,
  output logic                tap_rd_vld,
  output logic [AW-1:0]       tap_wr_address,
  output logic                tap_wr_vld,
  output logic [LANES*DW-1:0] tap_wr_data,
  output logic                tap_inter,
  output logic                tap_inter_first,
  output logic [2:0]          tap_sub_addr,
  output logic                tap_sub_vld,
  output logic [DW-1:0]       tap_sub_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [AW:0] C_ONE = (AW+1)'(1);

  state_t              r_state, w_state_nxt;
  logic [AW:0]         r_cnt, w_cnt_nxt;
  logic [AW:0]         r_rows, w_rows_nxt;
  logic                r_inter, w_inter_nxt;
  logic                r_last_issued, w_last_nxt;
  logic                w_idle, w_lane_ok, w_last;
  logic                w_rd_vld, w_wr_vld, w_sub_vld, w_tinter, w_tfirst, w_ld_err;
  logic [AW-1:0]       w_rd_addr, w_wr_addr;
  logic [LANES*DW-1:0] w_wr_data;
  logic [2:0]          w_sub_addr;
  logic [DW-1:0]       w_sub_data;

  // Grants are suppressed while reset is asserted so every output reads 0.
  assign w_idle    = (r_state == IDLE) & reset;
  assign ld_rdy    = w_idle & ld_vld;
  assign upd_rdy   = w_idle & upd_vld & ~ld_vld;
  assign fwd_ack   = w_idle & fwd_req & ~ld_vld & ~upd_vld;
  assign busy      = (r_state != IDLE);
  assign w_lane_ok = (32'(ld_lane) < 32'(LANES));
  assign w_last    = (r_cnt == (r_rows - C_ONE));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rows_nxt  = r_rows;
    w_inter_nxt = r_inter;
    w_last_nxt  = 1'b0;
    w_rd_vld    = 1'b0;
    w_rd_addr   = tap_rd_address;
    w_wr_vld    = 1'b0;
    w_wr_addr   = tap_wr_address;
    w_wr_data   = tap_wr_data;
    w_sub_vld   = 1'b0;
    w_sub_addr  = tap_sub_addr;
    w_sub_data  = tap_sub_data;
    w_tinter    = 1'b0;
    w_tfirst    = 1'b0;
    w_ld_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_rdy) begin
          if (w_lane_ok) begin
            w_state_nxt = WR;
            w_sub_vld   = 1'b1;
            w_sub_addr  = ld_lane;
            w_sub_data  = ld_data;
            w_wr_addr   = ld_addr;
          end else begin
            w_ld_err = 1'b1;
          end
        end else if (upd_rdy) begin
          w_state_nxt = WR;
          w_wr_vld    = 1'b1;
          w_wr_addr   = upd_addr;
          w_wr_data   = upd_data;
        end else if (fwd_ack) begin
          w_state_nxt = FWD;
          w_cnt_nxt   = '0;
          w_rows_nxt  = (fwd_rows == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, fwd_rows};
          w_inter_nxt = fwd_inter;
        end
      end
      FWD: begin
        if (!fwd_hold) begin
          w_rd_vld   = 1'b1;
          w_rd_addr  = r_cnt[AW-1:0];
          w_tinter   = r_inter;
          w_tfirst   = r_inter & (r_cnt == '0);
          w_last_nxt = w_last;
          w_cnt_nxt  = r_cnt + C_ONE;
          if (w_last) begin
            w_state_nxt = IDLE;
          end
        end
      end
      WR:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_rows          <= '0;
      r_inter         <= 1'b0;
      r_last_issued   <= 1'b0;
      tap_rd_vld      <= 1'b0;
      tap_rd_address  <= '0;
      tap_wr_vld      <= 1'b0;
      tap_wr_address  <= '0;
      tap_wr_data     <= '0;
      tap_sub_vld     <= 1'b0;
      tap_sub_addr    <= '0;
      tap_sub_data    <= '0;
      tap_inter       <= 1'b0;
      tap_inter_first <= 1'b0;
      ld_err          <= 1'b0;
      rd_data_vld     <= 1'b0;
      fwd_done        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_rows          <= w_rows_nxt;
      r_inter         <= w_inter_nxt;
      r_last_issued   <= w_last_nxt;
      tap_rd_vld      <= w_rd_vld;
      tap_rd_address  <= w_rd_addr;
      tap_wr_vld      <= w_wr_vld;
      tap_wr_address  <= w_wr_addr;
      tap_wr_data     <= w_wr_data;
      tap_sub_vld     <= w_sub_vld;
      tap_sub_addr    <= w_sub_addr;
      tap_sub_data    <= w_sub_data;
      tap_inter       <= w_tinter;
      tap_inter_first <= w_tfirst;
      ld_err          <= w_ld_err;
      // Read data returns one cycle after the read strobe.
      rd_data_vld     <= tap_rd_vld;
      fwd_done        <= tap_rd_vld & r_last_issued;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_full_st1_tap_ctrl.sv
`default_nettype none
// tb_full_st1_tap_ctrl: table-driven vectors with scoreboard queues for full_st1_tap_ctrl.
module tb_full_st1_tap_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fwd_req = 1'b0, fwd_inter = 1'b0, fwd_hold = 1'b0;
  logic [3:0] fwd_rows = '0;
  logic upd_vld = 1'b0;
  logic [3:0] upd_addr = '0;
  logic [191:0] upd_data = '0;
  logic ld_vld = 1'b0;
  logic [2:0] ld_lane = '0;
  logic [3:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic fwd_ack, fwd_done, rd_data_vld, upd_rdy, ld_rdy, ld_err, busy;
  logic [3:0] tap_rd_address, tap_wr_address;
  logic tap_rd_vld, tap_wr_vld, tap_inter, tap_inter_first, tap_sub_vld;
  logic [191:0] tap_wr_data;
  logic [2:0] tap_sub_addr;
  logic [31:0] tap_sub_data;

  full_st1_tap_ctrl #(.AW(4), .LANES(6), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .fwd_req(fwd_req), .fwd_inter(fwd_inter), .fwd_rows(fwd_rows), .fwd_hold(fwd_hold),
    .fwd_ack(fwd_ack), .fwd_done(fwd_done), .rd_data_vld(rd_data_vld),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy), .upd_addr(upd_addr), .upd_data(upd_data),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_lane(ld_lane), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_err(ld_err), .busy(busy),
    .tap_rd_address(tap_rd_address), .tap_rd_vld(tap_rd_vld),
    .tap_wr_address(tap_wr_address), .tap_wr_vld(tap_wr_vld), .tap_wr_data(tap_wr_data),
    .tap_inter(tap_inter), .tap_inter_first(tap_inter_first),
    .tap_sub_addr(tap_sub_addr), .tap_sub_vld(tap_sub_vld), .tap_sub_data(tap_sub_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] addr; logic inter; logic first; logic last; } rd_exp_t;
  typedef struct packed { logic [2:0] lane; logic [3:0] addr; logic [31:0] data; } sub_exp_t;
  typedef struct packed { logic [3:0] addr; logic [191:0] data; } wr_exp_t;

  localparam int K_FWD = 0, K_LD = 1, K_UPD = 2;
  typedef struct {
    int kind; logic inter; logic [3:0] rows; logic [31:0] hold;
    logic [2:0] lane; logic [3:0] addr; logic [31:0] data; logic [191:0] row;
    logic exp_err; int exp_reads;
  } vec_t;

  rd_exp_t  rdq[$];
  sub_exp_t subq[$];
  wr_exp_t  wrq[$];
  logic     errq[$];
  int nvec = 0, nfail = 0;
  logic mon_en = 1'b0, rst_s = 1'b0;
  logic exp_rdv_next = 1'b0, exp_done_next = 1'b0;

  always @(posedge clk) rst_s <= reset;

  // Output monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_s) begin
        nvec++;
        if ({tap_rd_vld, tap_wr_vld, tap_sub_vld, tap_inter, tap_inter_first, rd_data_vld,
             fwd_done, ld_err, busy, tap_rd_address, tap_wr_address, tap_sub_addr} != '0 ||
            tap_wr_data != '0 || tap_sub_data != '0) begin
          nfail++;
          $display("FAIL reset_state got rdv=%b wrv=%b subv=%b done=%b busy=%b rda=%h wra=%h exp all 0",
                   tap_rd_vld, tap_wr_vld, tap_sub_vld, fwd_done, busy, tap_rd_address, tap_wr_address);
        end
        exp_rdv_next = 1'b0;
        exp_done_next = 1'b0;
      end else begin
        nvec++;
        if (rd_data_vld !== exp_rdv_next || fwd_done !== exp_done_next) begin
          nfail++;
          $display("FAIL rd_pipe got rd_data_vld=%b fwd_done=%b exp %b %b",
                   rd_data_vld, fwd_done, exp_rdv_next, exp_done_next);
        end
        exp_rdv_next = 1'b0;
        exp_done_next = 1'b0;
        nvec++;
        if (tap_rd_vld) begin
          if (rdq.size() == 0) begin
            nfail++;
            $display("FAIL rd_unexpected got addr=%h exp no read", tap_rd_address);
          end else begin
            rd_exp_t e;
            e = rdq.pop_front();
            if ({tap_rd_address, tap_inter, tap_inter_first} !== {e.addr, e.inter, e.first}) begin
              nfail++;
              $display("FAIL rd_beat got addr=%h inter=%b first=%b exp addr=%h inter=%b first=%b",
                       tap_rd_address, tap_inter, tap_inter_first, e.addr, e.inter, e.first);
            end
            exp_rdv_next = 1'b1;
            exp_done_next = e.last;
          end
        end else if (tap_inter || tap_inter_first) begin
          nfail++;
          $display("FAIL inter_quiet got inter=%b first=%b exp 0 0", tap_inter, tap_inter_first);
        end
        if (tap_sub_vld) begin
          nvec++;
          if (subq.size() == 0) begin
            nfail++;
            $display("FAIL sub_unexpected got lane=%0d addr=%h exp no write", tap_sub_addr, tap_wr_address);
          end else begin
            sub_exp_t s;
            s = subq.pop_front();
            if ({tap_sub_addr, tap_wr_address, tap_sub_data, tap_wr_vld} !== {s.lane, s.addr, s.data, 1'b0}) begin
              nfail++;
              $display("FAIL sub_write got lane=%0d addr=%h data=%h wrv=%b exp lane=%0d addr=%h data=%h wrv=0",
                       tap_sub_addr, tap_wr_address, tap_sub_data, tap_wr_vld, s.lane, s.addr, s.data);
            end
          end
        end
        if (tap_wr_vld) begin
          nvec++;
          if (wrq.size() == 0) begin
            nfail++;
            $display("FAIL wr_unexpected got addr=%h exp no write", tap_wr_address);
          end else begin
            wr_exp_t w;
            w = wrq.pop_front();
            if ({tap_wr_address, tap_wr_data, tap_sub_vld} !== {w.addr, w.data, 1'b0}) begin
              nfail++;
              $display("FAIL row_write got addr=%h subv=%b data=%h exp addr=%h data=%h",
                       tap_wr_address, tap_sub_vld, tap_wr_data, w.addr, w.data);
            end
          end
        end
        if (ld_err) begin
          nvec++;
          if (errq.size() == 0) begin
            nfail++;
            $display("FAIL ld_err_unexpected got 1 exp 0");
          end else begin
            void'(errq.pop_front());
          end
        end
      end
    end
  end

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    nvec++;
    if (rdq.size() + subq.size() + wrq.size() + errq.size() != 0 || busy) begin
      nfail++;
      $display("FAIL drain got pending rd=%0d sub=%0d wr=%0d err=%0d busy=%b exp all 0",
               rdq.size(), subq.size(), wrq.size(), errq.size(), busy);
    end
  endtask

  task automatic push_reads(input logic inter, input int n, input int upto, input logic has_last);
    for (int i = 0; i < upto; i++) begin
      rd_exp_t e;
      e.addr = i[3:0];
      e.inter = inter;
      e.first = inter && (i == 0);
      e.last = has_last && (i == n - 1);
      rdq.push_back(e);
    end
  endtask

  task automatic run_fwd(input logic inter, input logic [3:0] rows, input logic [31:0] hold,
                         input int n, output int waited);
    int k, c, issued;
    waited = 0;
    fwd_inter = inter; fwd_rows = rows; fwd_req = 1'b1;
    @(negedge clk);
    while (!fwd_ack && waited < 50) begin @(negedge clk); waited++; end
    nvec++;
    if (!fwd_ack) begin
      nfail++;
      $display("FAIL fwd_ack_timeout got 0 exp 1");
      fwd_req = 1'b0;
      return;
    end
    push_reads(inter, n, n, 1'b1);
    @(posedge clk); #1;
    fwd_req = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      fwd_hold = (k < 32) ? hold[k] : 1'b0;
      @(posedge clk); #1;
      k++;
    end
    fwd_hold = 1'b0;
    c = 0; issued = 0;
    while (issued < n) begin
      if (!(c < 32 && hold[c])) issued++;
      c++;
    end
    nvec++;
    if (k != c) begin
      nfail++;
      $display("FAIL fwd_cycles got %0d exp %0d", k, c);
    end
    drain();
  endtask

  task automatic do_ld(input logic [2:0] lane, input logic [3:0] addr, input logic [31:0] data,
                       input logic exp_err);
    int g = 0;
    ld_lane = lane; ld_addr = addr; ld_data = data; ld_vld = 1'b1;
    @(negedge clk);
    while (!ld_rdy && g < 50) begin @(negedge clk); g++; end
    nvec++;
    if (!ld_rdy) begin
      nfail++;
      $display("FAIL ld_handshake got 0 exp 1");
    end else if (exp_err) errq.push_back(1'b1);
    else subq.push_back({lane, addr, data});
    @(posedge clk); #1;
    ld_vld = 1'b0;
    drain();
  endtask

  task automatic do_upd(input logic [3:0] addr, input logic [191:0] row);
    int g = 0;
    upd_addr = addr; upd_data = row; upd_vld = 1'b1;
    @(negedge clk);
    while (!upd_rdy && g < 50) begin @(negedge clk); g++; end
    nvec++;
    if (!upd_rdy) begin
      nfail++;
      $display("FAIL upd_handshake got 0 exp 1");
    end else wrq.push_back({addr, row});
    @(posedge clk); #1;
    upd_vld = 1'b0;
    drain();
  endtask

  function automatic logic [191:0] rand_row();
    logic [191:0] r;
    for (int j = 0; j < 6; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(input int kind, input logic inter, input logic [3:0] rows,
                              input logic [31:0] hold, input logic [2:0] lane, input logic [3:0] addr,
                              input logic [31:0] data, input logic exp_err, input int exp_reads);
    vec_t v;
    v.kind = kind; v.inter = inter; v.rows = rows; v.hold = hold; v.lane = lane; v.addr = addr;
    v.data = data; v.row = rand_row(); v.exp_err = exp_err; v.exp_reads = exp_reads;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    logic [2:0] grants[5];
    int waited, g;
    vt[0]  = mk(K_FWD, 1'b0, 4'd6,  32'h0,   3'd0, 4'd0, 32'h0,        1'b0, 6);
    vt[1]  = mk(K_FWD, 1'b1, 4'd3,  32'h2,   3'd0, 4'd0, 32'h0,        1'b0, 3);
    vt[2]  = mk(K_FWD, 1'b0, 4'd0,  32'h0,   3'd0, 4'd0, 32'h0,        1'b0, 16);
    vt[3]  = mk(K_LD,  1'b0, 4'd0,  32'h0,   3'd7, 4'd3, 32'h12345678, 1'b1, 0);
    vt[4]  = mk(K_LD,  1'b0, 4'd0,  32'h0,   3'd2, 4'd5, 32'hDEADBEEF, 1'b0, 0);
    vt[5]  = mk(K_UPD, 1'b0, 4'd0,  32'h0,   3'd0, 4'd9, 32'h0,        1'b0, 0);
    vt[6]  = mk(K_LD,  1'b0, 4'd0,  32'h0,   3'd6, 4'd1, 32'hA5A5A5A5, 1'b1, 0);
    vt[7]  = mk(K_LD,  1'b0, 4'd0,  32'h0,   3'd5, 4'd15, 32'hCAFEF00D, 1'b0, 0);
    vt[8]  = mk(K_FWD, 1'b1, 4'd1,  32'h1,   3'd0, 4'd0, 32'h0,        1'b0, 1);
    vt[9]  = mk(K_FWD, 1'b1, 4'd5,  32'h2A,  3'd0, 4'd0, 32'h0,        1'b0, 5);
    vt[10] = mk(K_UPD, 1'b0, 4'd0,  32'h0,   3'd0, 4'd0, 32'h0,        1'b0, 0);
    vt[11] = mk(K_FWD, 1'b0, 4'd15, 32'h9,   3'd0, 4'd0, 32'h0,        1'b0, 15);

    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      case (vt[i].kind)
        K_FWD:   run_fwd(vt[i].inter, vt[i].rows, vt[i].hold, vt[i].exp_reads, waited);
        K_LD:    do_ld(vt[i].lane, vt[i].addr, vt[i].data, vt[i].exp_err);
        default: do_upd(vt[i].addr, vt[i].row);
      endcase
    end

    // Simultaneous requesters: ld, then upd, then fwd, one WR cycle in between each.
    grants[0] = 3'b100; grants[1] = 3'b000; grants[2] = 3'b010; grants[3] = 3'b000; grants[4] = 3'b001;
    ld_lane = 3'd1; ld_addr = 4'd4; ld_data = 32'h0BADF00D; ld_vld = 1'b1;
    upd_addr = 4'd7; upd_data = rand_row(); upd_vld = 1'b1;
    fwd_inter = 1'b0; fwd_rows = 4'd2; fwd_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nvec++;
      if ({ld_rdy, upd_rdy, fwd_ack} !== grants[c]) begin
        nfail++;
        $display("FAIL grant_c%0d got %b exp %b", c, {ld_rdy, upd_rdy, fwd_ack}, grants[c]);
      end
      if (c == 0) subq.push_back({3'd1, 4'd4, 32'h0BADF00D});
      if (c == 2) wrq.push_back({upd_addr, upd_data});
      if (c == 4) push_reads(1'b0, 2, 2, 1'b1);
      @(posedge clk); #1;
      if (c == 0) ld_vld = 1'b0;
      if (c == 2) upd_vld = 1'b0;
      if (c == 4) fwd_req = 1'b0;
    end
    g = 0;
    while (busy && g < 50) begin @(posedge clk); #1; g++; end
    drain();

    // Reset in the middle of a 6-row sweep, after rows 0..2 have issued.
    fwd_inter = 1'b0; fwd_rows = 4'd6; fwd_req = 1'b1;
    @(negedge clk);
    nvec++;
    if (!fwd_ack) begin
      nfail++;
      $display("FAIL abort_ack got 0 exp 1");
    end
    push_reads(1'b0, 6, 3, 1'b0);
    @(posedge clk); #1;
    fwd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (busy !== 1'b0 || rdq.size() != 0) begin
      nfail++;
      $display("FAIL abort_state got busy=%b pending=%0d exp busy=0 pending=0", busy, rdq.size());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_fwd(1'b0, 4'd6, 32'h0, 6, waited);
    nvec++;
    if (waited != 0) begin
      nfail++;
      $display("FAIL ack_after_reset got wait=%0d exp 0", waited);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
